// File: rtl/led7seg_pkg.sv
// Shared sizes, state types and segment encoding for the 8-digit 74HC595 scan controller.
package led7seg_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int WORD_W     = 16;
    localparam int IDX_W      = $clog2(NUM_DIGITS);
    localparam int BIT_W      = $clog2(WORD_W);

    // Serial sequencer phases; HOLD belongs to the scan controller's dwell.
    typedef enum logic [2:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LATCH,
        HOLD
    } scan_state_t;

    typedef enum logic [1:0] {
        CTRL_IDLE,
        CTRL_XFER,
        CTRL_HOLD
    } ctrl_state_t;

    // Active-low {dp,g,f,e,d,c,b,a}, decimal point off.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'h0: seg = 8'hC0;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            default: seg = 8'h8E;
        endcase
        return seg;
    endfunction

    // Blank overrides the decimal point; select is one-hot on the digit index.
    function automatic logic [WORD_W-1:0] make_word(
        input logic [IDX_W-1:0]        idx,
        input logic [4*NUM_DIGITS-1:0] digs,
        input logic [NUM_DIGITS-1:0]   dp,
        input logic [NUM_DIGITS-1:0]   blank
    );
        logic [7:0]            seg;
        logic [NUM_DIGITS-1:0] sel;
        seg = hex_to_seg(digs[{idx, 2'b00} +: 4]);
        if (dp[idx]) seg[7] = 1'b0;
        if (blank[idx]) seg = 8'hFF;
        sel      = '0;
        sel[idx] = 1'b1;
        return {seg, sel};
    endfunction

endpackage

// File: rtl/led7seg_595_shifter.sv
// Shifts one 16-bit word MSB-first into a 74HC595 chain, then pulses the storage clock.
module led7seg_595_shifter
    import led7seg_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WORD_W-1:0] word,
    output logic              done,
    output logic              sclk,
    output logic              rclk,
    output logic              dio
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    scan_state_t       state_q, state_d;
    logic [7:0]        div_q;
    logic [BIT_W-1:0]  bit_q;
    logic [WORD_W-1:0] word_q;
    logic              div_last;

    assign div_last = (div_q == DIV_LAST);

    always_comb begin
        // NOTE: every output and the next state get a default first, so no path infers a latch.
        state_d = state_q;
        done    = 1'b0;
        sclk    = 1'b0;
        rclk    = 1'b0;
        dio     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = SHIFT_LO;
            end
            SHIFT_LO: begin
                dio = word_q[bit_q];
                if (div_last) state_d = SHIFT_HI;
            end
            SHIFT_HI: begin
                sclk = 1'b1;
                dio  = word_q[bit_q];
                if (div_last) state_d = (bit_q == '0) ? LATCH : SHIFT_LO;
            end
            LATCH: begin
                rclk = 1'b1;
                // done is combinational so the controller enters its dwell with no gap cycle.
                if (div_last) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            word_q  <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            if (state_q == IDLE || div_last) div_q <= '0;
            else                             div_q <= div_q + 8'd1;
            if (state_q == IDLE && start) begin
                word_q <= word;
                bit_q  <= BIT_W'(WORD_W - 1);
            end else if (state_q == SHIFT_HI && div_last) begin
                bit_q <= bit_q - BIT_W'(1);
            end
        end
    end

endmodule

// File: rtl/led7seg_scan_ctrl.sv
// Eight-digit multiplexed display scanner: owns digit index, double-buffered shadows and dwell timing.
module led7seg_scan_ctrl
    import led7seg_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int DWELL   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [31:0] digits,
    input  logic [7:0]  dp_mask,
    input  logic [7:0]  blank_mask,
    output logic        sclk,
    output logic        rclk,
    output logic        dio,
    output logic        busy,
    output logic        frame_done
);

    localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);

    ctrl_state_t       state_q, state_d;
    logic [IDX_W-1:0]  idx_q, word_idx;
    logic [15:0]       dwell_q;
    logic              dwell_last;
    logic              start, xfer_done, advance, take_commit;
    logic [WORD_W-1:0] word;

    logic [31:0] pend_digits_q, act_digits_q, commit_digits, next_digits;
    logic [7:0]  pend_dp_q, act_dp_q, commit_dp, next_dp;
    logic [7:0]  pend_blank_q, act_blank_q, commit_blank, next_blank;

    // A load in the commit cycle itself is what gets committed.
    assign commit_digits = load ? digits     : pend_digits_q;
    assign commit_dp     = load ? dp_mask    : pend_dp_q;
    assign commit_blank  = load ? blank_mask : pend_blank_q;

    assign dwell_last = (dwell_q == DWELL_LAST);

    always_comb begin
        state_d     = state_q;
        start       = 1'b0;
        advance     = 1'b0;
        take_commit = 1'b0;
        frame_done  = 1'b0;
        word_idx    = idx_q;
        unique case (state_q)
            CTRL_IDLE: begin
                take_commit = 1'b1;
                if (en) begin
                    start   = 1'b1;
                    state_d = CTRL_XFER;
                end
            end
            CTRL_XFER: begin
                if (xfer_done) state_d = CTRL_HOLD;
            end
            CTRL_HOLD: begin
                if (dwell_last) begin
                    advance     = 1'b1;
                    word_idx    = idx_q + IDX_W'(1);
                    take_commit = (idx_q == IDX_W'(NUM_DIGITS - 1));
                    frame_done  = take_commit;
                    if (en) begin
                        start   = 1'b1;
                        state_d = CTRL_XFER;
                    end else begin
                        state_d = CTRL_IDLE;
                    end
                end
            end
            default: state_d = CTRL_IDLE;
        endcase
    end

    // The word for the next digit is built from the shadow it will display with.
    assign next_digits = take_commit ? commit_digits : act_digits_q;
    assign next_dp     = take_commit ? commit_dp     : act_dp_q;
    assign next_blank  = take_commit ? commit_blank  : act_blank_q;
    assign word        = make_word(word_idx, next_digits, next_dp, next_blank);
    assign busy        = (state_q != CTRL_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= CTRL_IDLE;
            idx_q         <= '0;
            dwell_q       <= '0;
            // NOTE: shadow registers are reset explicitly; blank mask all-ones keeps the display dark.
            pend_digits_q <= '0;
            pend_dp_q     <= '0;
            pend_blank_q  <= '1;
            act_digits_q  <= '0;
            act_dp_q      <= '0;
            act_blank_q   <= '1;
        end else begin
            state_q <= state_d;
            if (advance) idx_q <= word_idx;
            if (state_q == CTRL_HOLD && !dwell_last) dwell_q <= dwell_q + 16'd1;
            else                                     dwell_q <= '0;
            if (load) begin
                pend_digits_q <= digits;
                pend_dp_q     <= dp_mask;
                pend_blank_q  <= blank_mask;
            end
            act_digits_q <= next_digits;
            act_dp_q     <= next_dp;
            act_blank_q  <= next_blank;
        end
    end

    led7seg_595_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .word  (word),
        .done  (xfer_done),
        .sclk  (sclk),
        .rclk  (rclk),
        .dio   (dio)
    );

endmodule

// File: tb/tb_led7seg_scan_ctrl.sv
// Bench for led7seg_scan_ctrl: cycle-level reference model plus a 74HC595 receiver emulation.
module tb_led7seg_scan_ctrl;

    localparam int CLK_DIV = 2;
    localparam int DWELL   = 4;
    localparam int P       = 33 * CLK_DIV + DWELL;
    localparam int BUDGET  = 12 * 8 * P;

    localparam logic [7:0] SEG_TBL [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [31:0] digits = '0;
    logic [7:0]  dp_mask = '0;
    logic [7:0]  blank_mask = '0;
    logic        sclk, rclk, dio, busy, frame_done;

    int vectors = 0;
    int miscompares = 0;

    led7seg_scan_ctrl #(
        .CLK_DIV (CLK_DIV),
        .DWELL   (DWELL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load       (load),
        .digits     (digits),
        .dp_mask    (dp_mask),
        .blank_mask (blank_mask),
        .sclk       (sclk),
        .rclk       (rclk),
        .dio        (dio),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_word(input int idx, input logic [31:0] d,
                                             input logic [7:0] dp, input logic [7:0] bl);
        logic [7:0] seg;
        logic [3:0] nib;
        nib = d[4*idx +: 4];
        seg = SEG_TBL[nib];
        if (dp[idx]) seg[7] = 1'b0;
        if (bl[idx]) seg = 8'hFF;
        return {seg, 8'(1 << idx)};
    endfunction

    // Reference model: position within a digit period, digit index, two shadow copies.
    bit          m_active = 1'b0;
    int          m_pos = 0;
    int          m_idx = 0;
    logic [15:0] m_word = '0;
    logic [31:0] m_pd = '0, m_ad = '0;
    logic [7:0]  m_pdp = '0, m_adp = '0, m_pbl = 8'hFF, m_abl = 8'hFF;

    task automatic model_reset();
        m_active = 1'b0; m_pos = 0; m_idx = 0; m_word = '0;
        m_pd = '0; m_pdp = '0; m_pbl = 8'hFF;
        m_ad = '0; m_adp = '0; m_abl = 8'hFF;
    endtask

    function automatic logic [4:0] model_outs();
        logic s, r, d, b, f;
        s = 1'b0; r = 1'b0; d = 1'b0; b = 1'b0; f = 1'b0;
        if (m_active) begin
            b = 1'b1;
            if (m_pos < 32 * CLK_DIV) begin
                s = ((m_pos / CLK_DIV) % 2) == 1;
                d = m_word[15 - m_pos / (2 * CLK_DIV)];
            end else if (m_pos < 33 * CLK_DIV) begin
                r = 1'b1;
            end else begin
                f = (m_idx == 7) && (m_pos == P - 1);
            end
        end
        return {s, r, d, b, f};
    endfunction

    task automatic model_step();
        logic [31:0] cd;
        logic [7:0]  cdp, cbl;
        cd  = load ? digits : m_pd;
        cdp = load ? dp_mask : m_pdp;
        cbl = load ? blank_mask : m_pbl;
        if (!m_active) begin
            m_ad = cd; m_adp = cdp; m_abl = cbl;
            if (en) begin
                m_active = 1'b1;
                m_pos    = 0;
                m_word   = ref_word(m_idx, m_ad, m_adp, m_abl);
            end
        end else if (m_pos == P - 1) begin
            if (m_idx == 7) begin
                m_ad = cd; m_adp = cdp; m_abl = cbl;
            end
            m_idx = (m_idx + 1) % 8;
            m_pos = 0;
            if (en) m_word = ref_word(m_idx, m_ad, m_adp, m_abl);
            else    m_active = 1'b0;
        end else begin
            m_pos++;
        end
        if (load) begin
            m_pd = digits; m_pdp = dp_mask; m_pbl = blank_mask;
        end
    endtask

    // Receiver emulation and per-cycle comparison, sampled on the falling edge.
    logic [15:0] sr = '0;
    logic        prev_sclk = 1'b0, prev_rclk = 1'b0;
    logic [15:0] lq[$];
    int          lt[$];
    int          fq[$];
    int          cyc = 0;

    always @(negedge clk) begin
        if (!rst) model_reset();
        check("outs{sclk,rclk,dio,busy,fd}", {27'd0, sclk, rclk, dio, busy, frame_done},
              {27'd0, model_outs()});
        if (sclk && !prev_sclk) sr = {sr[14:0], dio};
        if (rclk && !prev_rclk) begin
            check("latched_word", sr, m_word);
            lq.push_back(sr);
            lt.push_back(cyc);
        end
        if (frame_done) fq.push_back(cyc);
        prev_sclk = sclk;
        prev_rclk = rclk;
        if (rst) model_step();
        cyc++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] bl);
        digits = d; dp_mask = dp; blank_mask = bl; load = 1'b1;
        tick(1);
        load = 1'b0;
    endtask

    task automatic wait_latches(input int n, input string tag);
        int b = 0;
        while (lq.size() < n && b < BUDGET) begin
            tick(1);
            b++;
        end
        check({tag, "_wait"}, 32'(lq.size() >= n), 32'd1);
    endtask

    task automatic wait_frame(input string tag);
        int n = fq.size();
        int b = 0;
        while (fq.size() == n && b < BUDGET) begin
            tick(1);
            b++;
        end
        check({tag, "_wait"}, 32'(fq.size() > n), 32'd1);
    endtask

    task automatic wait_pos(input int idx, input int pos, input string tag);
        int b = 0;
        while (!(m_active && (idx < 0 || m_idx == idx) && m_pos == pos) && b < BUDGET) begin
            tick(1);
            b++;
        end
        check({tag, "_wait"}, 32'(m_active && (idx < 0 || m_idx == idx) && m_pos == pos), 32'd1);
    endtask

    initial begin
        logic [31:0] nd;
        logic [7:0]  ndp;
        logic [15:0] exp_w;
        int          lc;
        int          dig;

        #2 rst = 1'b0;
        tick(3);
        check("reset_outs", {27'd0, sclk, rclk, dio, busy, frame_done}, 32'd0);
        rst = 1'b1;

        // Power-up frame: dark digits, exact digit period.
        en = 1'b1;
        lq.delete(); lt.delete();
        wait_latches(2, "boot");
        check("boot_d0", lq[0], 16'hFF01);
        check("boot_d1", lq[1], 16'hFF02);
        check("digit_period", lt[1] - lt[0], P);

        // Plain hex load, visible from the next frame.
        do_load(32'h7654_3210, 8'h00, 8'h00);
        wait_frame("wrap_a");
        lq.delete();
        wait_latches(8, "frame_a");
        check("hex_d0", lq[0], 16'hC001);
        check("hex_d3", lq[3], 16'hB008);
        check("hex_d7", lq[7], 16'hF880);

        // Blank wins over decimal point.
        do_load(32'h0000_0008, 8'h01, 8'h81);
        wait_frame("wrap_b");
        lq.delete();
        wait_latches(2, "frame_b");
        check("blank_d0", lq[0], 16'hFF01);
        check("blank_d1", lq[1], 16'hC002);

        // Load landing on the commit cycle itself.
        wait_pos(7, P - 1, "wrap_cycle");
        do_load(32'h89AB_CDEF, 8'h00, 8'h00);
        lq.delete();
        wait_latches(1, "commit_same");
        check("commit_same_d0", lq[0], 16'h8E01);

        // Mid-frame load: digits 4..7 keep the old frame.
        wait_pos(4, 5, "mid_frame");
        nd  = $urandom;
        ndp = 8'($urandom);
        do_load(nd, ndp, 8'h00);
        lq.delete();
        wait_latches(8, "mixed");
        for (int i = 0; i < 8; i++) begin
            dig   = (4 + i) % 8;
            exp_w = (dig >= 4) ? ref_word(dig, 32'h89AB_CDEF, 8'h00, 8'h00)
                               : ref_word(dig, nd, ndp, 8'h00);
            check($sformatf("mixed_dig%0d", dig), lq[i], exp_w);
        end
        fq.delete();
        wait_frame("fd1");
        wait_frame("fd2");
        check("frame_period", fq[1] - fq[0], 8 * P);

        // Enable dropped mid-shift of digit 2.
        wait_pos(2, CLK_DIV, "dig2_hi");
        en = 1'b0;
        lq.delete();
        wait_latches(1, "dig2_finish");
        check("en_off_d2", lq[0], ref_word(2, nd, ndp, 8'h00));
        tick(DWELL + 2);
        check("en_off_idle", busy, 1'b0);
        tick(20);
        check("en_off_stay", busy, 1'b0);
        en = 1'b1;
        lq.delete();
        wait_latches(1, "resume");
        check("resume_d3", lq[0], ref_word(3, nd, ndp, 8'h00));

        // Reset during bit 9: outputs clear at once, partial word never latched.
        wait_pos(-1, 12 * CLK_DIV + 1, "bit9");
        lc = lq.size();
        #2 rst = 1'b0;
        #1 check("async_rst_outs", {27'd0, sclk, rclk, dio, busy, frame_done}, 32'd0);
        tick(3);
        check("rst_no_latch", lq.size(), lc);
        rst = 1'b1;
        lq.delete();
        wait_latches(1, "restart");
        check("restart_d0", lq[0], 16'hFF01);

        // Random loads and enable toggles against the model.
        for (int i = 0; i < 3000; i++) begin
            load = ($urandom_range(0, 47) == 0);
            if (load) begin
                digits     = $urandom;
                dp_mask    = 8'($urandom);
                blank_mask = 8'($urandom);
            end
            if ($urandom_range(0, 249) == 0) en = ~en;
            tick(1);
        end
        load = 1'b0;
        en   = 1'b1;
        tick(2 * P);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
